// File: rtl/vga_timing_controller.sv
// -----------------------------------------------------------------------------
// vga_timing_controller
//
// Raster sequencer for a 640x480 VGA display. A clock-enable divider marks the
// last system clock of every pixel period; on that clock the horizontal
// counter advances, and on a line wrap the vertical counter advances. Sync,
// display-enable and the line/frame start pulses are registered from the
// next-state counters so they always line up with the coordinates presented
// in the same cycle.
//
// Ports:
//   clock          in   system clock, all state changes on its rising edge
//   reset_n        in   asynchronous active-low reset
//   run            in   1 = raster running, 0 = held idle at the origin
//   pixel_tick     out  high on the last system clock of each pixel period
//   pixel_x        out  horizontal position, 0..H_TOTAL-1
//   pixel_y        out  vertical position, 0..V_TOTAL-1
//   hsync          out  horizontal sync, active low
//   vsync          out  vertical sync, active low
//   display_enable out  high inside the visible window
//   line_start     out  one-clock pulse when pixel_x becomes 0
//   frame_start    out  one-clock pulse when the position becomes (0,0)
// -----------------------------------------------------------------------------
module vga_timing_controller #(
  parameter int DIV    = 8,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_enable,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_e;

  typedef enum logic [1:0] {
    HP_VIS,
    HP_FP,
    HP_SYNC,
    HP_BP
  } h_phase_e;

  typedef enum logic [1:0] {
    VP_VIS,
    VP_FP,
    VP_SYNC,
    VP_BP
  } v_phase_e;

  // Horizontal phase is a pure decode of the pixel column.
  function automatic h_phase_e h_phase(input logic [9:0] x);
    if (x < 10'(H_VIS))                        return HP_VIS;
    else if (x < 10'(H_VIS + H_FP))            return HP_FP;
    else if (x < 10'(H_VIS + H_FP + H_SYNC))   return HP_SYNC;
    else                                       return HP_BP;
  endfunction

  // Vertical phase is a pure decode of the line number.
  function automatic v_phase_e v_phase(input logic [9:0] y);
    if (y < 10'(V_VIS))                        return VP_VIS;
    else if (y < 10'(V_VIS + V_FP))            return VP_FP;
    else if (y < 10'(V_VIS + V_FP + V_SYNC))   return VP_SYNC;
    else                                       return VP_BP;
  endfunction

  run_state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic       tick;
  h_phase_e   h_ph_d;
  v_phase_e   v_ph_d;

  assign tick = (state_q == ST_RUN) && (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        x_d   = '0;
        y_d   = '0;
        // Starting the raster is itself a line and frame boundary.
        if (run) begin
          state_d = ST_RUN;
          ls_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          // Abort immediately: no partial-line completion, no resume.
          state_d = ST_IDLE;
          div_d   = '0;
          x_d     = '0;
          y_d     = '0;
        end else if (tick) begin
          div_d = '0;
          if (x_q == H_LAST) begin
            x_d  = '0;
            ls_d = 1'b1;
            if (y_q == V_LAST) begin
              y_d  = '0;
              fs_d = 1'b1;
            end else begin
              y_d = y_q + 10'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next-state counters so they are aligned
    // with the coordinates that will be presented alongside them.
    h_ph_d  = h_phase(x_d);
    v_ph_d  = v_phase(y_d);
    hsync_d = !((state_d == ST_RUN) && (h_ph_d == HP_SYNC));
    vsync_d = !((state_d == ST_RUN) && (v_ph_d == VP_SYNC));
    de_d    = (state_d == ST_RUN) && (h_ph_d == HP_VIS) && (v_ph_d == VP_VIS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign pixel_tick     = tick;
  assign pixel_x        = x_q;
  assign pixel_y        = y_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign display_enable = de_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Sequences the VGA raster for the 640x480 @ ~60 Hz display. It divides the system clock into a pixel-tick enable and steps horizontal and vertical counters through visible, front-porch, sync and back-porch phases. It drives hsync/vsync, the display-enable window and the pixel coordinates to the frame renderer. All logic runs in the system clock domain; the pixel rate is a clock enable, not a derived clock.

## Interface
- DIV, 8: system clocks per pixel; legal range 1..255.
- H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal phase lengths in pixels (H_TOTAL = 800).
- V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33: vertical phase lengths in lines (V_TOTAL = 525).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = raster running, 0 = raster held idle at origin.
- pixel_tick  out  1  one-clock pulse marking the last clock of each pixel period.
- pixel_x  out  10  current horizontal position, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- display_enable  out  1  high while the position is inside the visible window.
- line_start  out  1  one-clock pulse when a line begins (pixel_x becomes 0).
- frame_start  out  1  one-clock pulse when a frame begins (position becomes 0,0).

## Operation
- **Reset (reset_n = 0), asynchronous:**
  - divider, pixel_x and pixel_y = 0;
  - hsync = 1, vsync = 1;
  - display_enable, pixel_tick, line_start and frame_start = 0;
  - internal running flag = 0.
- **Idle (running = 0):**
  - all state is held at its reset values.
  - On the first clock edge that samples run = 1: running goes to 1, display_enable goes to 1, and line_start and frame_start pulse for that one clock. The divider starts at 0.
- **Divider:** while running, counts 0..DIV-1 and wraps. pixel_tick = (div == DIV-1) & running, decoded combinationally. With DIV = 1, pixel_tick is high on every running clock.
- **Horizontal FSM**, state derived from pixel_x:
  - H_VIS: 0..639
  - H_FP: 640..655
  - H_SYNC: 656..751
  - H_BP: 752..799
  - On a tick edge pixel_x increments. At 799 it wraps to 0 and pixel_y advances.
- **Vertical FSM**, state derived from pixel_y:
  - V_VIS: 0..479
  - V_FP: 480..489
  - V_SYNC: 490..491
  - V_BP: 492..524
  - At 524, on a line wrap, pixel_y wraps to 0.
- **Registered outputs:** hsync, vsync and display_enable are registered, computed from next-state counters, so they always describe the pixel_x/pixel_y presented in the same cycle.
  - hsync = 0 iff in H_SYNC.
  - vsync = 0 iff in V_SYNC.
  - display_enable = running & H_VIS & V_VIS.
- **Start pulses:** registered, high for exactly one clock after the edge that moved pixel_x to 0 (line_start) or the position to (0,0) (frame_start). A frame wrap raises both.
- **run deasserted mid-frame:** on the next edge, state returns to idle/reset values. No partial-line completion; hsync and vsync go inactive immediately.
- **run re-asserted:** the frame restarts from (0,0) with frame_start. There is no resume.

## Timing
- Each pixel position is held for exactly DIV clocks.
- Line period = 800·DIV clocks; frame period = 420 000·DIV clocks. DIV = 1 at 25.2 MHz gives 60 Hz.
- hsync low for 96·DIV consecutive clocks per line, starting on the clock where pixel_x becomes 656.
- vsync low for 2 full lines (1600·DIV clocks), starting on the clock where pixel_y becomes 490 with pixel_x = 0.
- Output latency from run = 1 to the first frame_start is one clock edge.
- Counters are width-checked: pixel_x and pixel_y never exceed H_TOTAL-1 and V_TOTAL-1. No arithmetic overflow is possible in 10 bits.
- Reset dominates run at any time, including mid-line.

## Test plan
- **Reset values:** assert reset_n = 0 mid-run -> immediately hsync = 1, vsync = 1, display_enable = 0, pixel_x = pixel_y = 0, no pulses.
- **Line timing, DIV = 2:** run = 1 for one line -> display_enable high 1280 clocks, hsync low exactly 192 clocks starting at pixel_x = 656, line_start period 1600 clocks.
- **Frame wrap, DIV = 1:** advance to (799,524) then one tick -> position (0,0), frame_start and line_start both high for one clock; vsync low exactly 1600 clocks per frame.
- **Frame period, DIV = 8:** run frames continuously -> frame_start pulses exactly 3 360 000 clocks apart.
- **Mid-frame stop/restart:** deassert run at (300,200) -> next clock at idle values. Reassert run -> frame_start on that edge, position (0,0).
- **DIV = 1 tick check:** pixel_tick is constantly 1 while running, and pixel_x increments every clock.
